// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default parameters for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

   // Controller states: CLEAR sweeps zeros through the array, READY serves traffic.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int N_RD_DEF     = 2;
   localparam int ZERO_REG_DEF = 1;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with write bypass and entry-0 masking.
// Latency: zero cycles (pure combinational lookup).
// Backpressure: none; returns 0 while the file is not ready.
// Ports: ready_i (file in READY), ra_i (read address), mem_i (storage array),
//        we*_i/wa*_i/wd*_i (same-cycle write ports for bypass), rd_o (read data).
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF
) (
   input  logic              ready_i,
   input  logic [ADDR_W-1:0] ra_i,
   input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] wa0_i,
   input  logic [DATA_W-1:0] wd0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] wa1_i,
   input  logic [DATA_W-1:0] wd1_i,
   output logic [DATA_W-1:0] rd_o
);

   always_comb begin
      rd_o = mem_i[ra_i];
      // Bypass is evaluated port 0 then port 1 so port 1 wins on a shared address.
      if (we0_i && (wa0_i == ra_i)) rd_o = wd0_i;
      if (we1_i && (wa1_i == ra_i)) rd_o = wd1_i;
      // Storage is not reset, so nothing may leak out until the sweep is done.
      if (!ready_i) rd_o = '0;
      if ((ZERO_REG != 0) && (ra_i == '0)) rd_o = '0;
   end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2-write / N_RD-read register file with a zeroing sweep after reset or clr_req.
// Latency: writes land at the rising edge; reads are combinational with same-cycle bypass.
// Backpressure: ready low for DEPTH cycles during a sweep; writes in that window are dropped.
// Ports: clk, rst (async active-low), clr_req, ready, we0/we1, wa0/wa1, wd0/wd1,
//        ra (N_RD packed addresses), rd (N_RD packed data words).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int N_RD     = N_RD_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_req,
   output logic                   ready,
   input  logic                   we0,
   input  logic                   we1,
   input  logic [ADDR_W-1:0]      wa0,
   input  logic [ADDR_W-1:0]      wa1,
   input  logic [DATA_W-1:0]      wd0,
   input  logic [DATA_W-1:0]      wd1,
   input  logic [N_RD*ADDR_W-1:0] ra,
   output logic [N_RD*DATA_W-1:0] rd
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic clearing;
   logic byp0, byp1;
   logic wr0_en, wr1_en;

   assign clearing = (state_q == CLEAR);
   assign ready    = (state_q == READY);

   // Bypass follows the raw enables in READY; the commit additionally drops
   // the clr_req cycle and writes to the hardwired-zero entry.
   assign byp0   = !clearing && we0;
   assign byp1   = !clearing && we1;
   assign wr0_en = byp0 && !clr_req && !((ZERO_REG != 0) && (wa0 == '0));
   assign wr1_en = byp1 && !clr_req && !((ZERO_REG != 0) && (wa1 == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         CLEAR: begin
            // clr_cnt parks on the last index rather than wrapping.
            if (clr_cnt_q == LAST_IDX) state_d = READY;
            else                       clr_cnt_d = clr_cnt_q + 1'b1;
         end
         READY: begin
            if (clr_req) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Single writer for the array; port 1 is assigned last so it wins on a collision.
   always_ff @(posedge clk) begin
      if (clearing) begin
         mem_q[clr_cnt_q] <= '0;
      end else begin
         if (wr0_en) mem_q[wa0] <= wd0;
         if (wr1_en) mem_q[wa1] <= wd1;
      end
   end

   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_rd_port (
         .ready_i (ready),
         .ra_i    (ra[k*ADDR_W +: ADDR_W]),
         .mem_i   (mem_q),
         .we0_i   (byp0),
         .wa0_i   (wa0),
         .wd0_i   (wd0),
         .we1_i   (byp1),
         .wa1_i   (wa1),
         .wd1_i   (wd1),
         .rd_o    (rd[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with default parameters.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later.
// Backpressure: models the DEPTH-cycle sweep and expects ready to follow it.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           clr_req;
   logic           ready;
   logic           we0, we1;
   logic [AW-1:0]  wa0, wa1;
   logic [DW-1:0]  wd0, wd1;
   logic [NR*AW-1:0] ra;
   logic [NR*DW-1:0] rd;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr_req (clr_req),
      .ready   (ready),
      .we0     (we0),
      .we1     (we1),
      .wa0     (wa0),
      .wa1     (wa1),
      .wd0     (wd0),
      .wd1     (wd1),
      .ra      (ra),
      .rd      (rd)
   );

   // Reference model
   logic [DW-1:0] model [DEPTH];
   logic          m_ready;
   int            m_cnt;

   typedef struct {
      string         tag;
      int            port;
      logic [DW-1:0] exp;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input logic e0,
         input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic e1,
         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      if (!m_ready || a == '0) return '0;
      if (e1 && a1 == a) return d1;
      if (e0 && a0 == a) return d0;
      return model[a];
   endfunction

   // One clock of stimulus: drive on the falling edge, score reads and ready,
   // then advance the model across the following rising edge.
   task automatic cyc(input logic r, input logic c,
         input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
         input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
         input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string tag);
      exp_t e;
      @(negedge clk);
      rst = r; clr_req = c;
      we0 = e0; wa0 = a0; wd0 = d0;
      we1 = e1; wa1 = a1; wd1 = d1;
      ra[0 +: AW] = r0;
      ra[AW +: AW] = r1;
      if (!r) model_reset();
      sb.push_back('{tag: {tag, ".rd0"}, port: 0, exp: exp_read(r0, e0, a0, d0, e1, a1, d1)});
      sb.push_back('{tag: {tag, ".rd1"}, port: 1, exp: exp_read(r1, e0, a0, d0, e1, a1, d1)});
      #1;
      check_val({tag, ".ready"}, {31'b0, ready}, {31'b0, m_ready});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, rd[e.port*DW +: DW], e.exp);
      end
      @(posedge clk);
      if (!r) begin
         model_reset();
      end else if (!m_ready) begin
         if (m_cnt == DEPTH-1) m_ready = 1'b1;
         else                  m_cnt++;
      end else if (c) begin
         model_reset();
      end else begin
         if (e0 && a0 != '0) model[a0] = d0;
         if (e1 && a1 != '0) model[a1] = d1;
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0,
             AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)), tag);
   endtask

   initial begin
      rst = 1'b0; clr_req = 1'b0;
      we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
      model_reset();

      // Reset held, then release: 32 cycles not ready, ready on the 33rd.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd9, "rst");
      idle(DEPTH + 2, "sweep");

      // Same-cycle bypass then stored value.
      cyc(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, 5'd6, "byp");
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd5, "stored");

      // Collision: port 1 wins in bypass and in storage.
      cyc(1'b1, 1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7, 5'd5, "dual");
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd7, "dual_st");

      // Entry 0 stays zero.
      cyc(1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "zero_wr");
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 5'd0, "zero_rd");

      // Random traffic.
      for (int i = 0; i < 40; i++)
         cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), $urandom(),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), $urandom(),
             AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)), "rand");

      // Fill 1..31, then clear (the write in the clr_req cycle is discarded).
      for (int a = 1; a < DEPTH; a++)
         cyc(1'b1, 1'b0, 1'b1, AW'(a), 32'h8000_0000 | DW'(a), 1'b0, '0, '0, AW'(a), AW'(a - 1), "fill");
      cyc(1'b1, 1'b1, 1'b1, 5'd3, 32'hAAAA_5555, 1'b0, '0, '0, 5'd3, 5'd4, "clr");
      // Writes and repeated clr_req during the sweep must be ignored.
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, AW'(i), 32'h1234_0000 | DW'(i), 1'b1, AW'(DEPTH-1-i),
             32'h5678_0000, AW'($urandom_range(0, DEPTH-1)), AW'(i), "clr_sweep");
      for (int a = 0; a < DEPTH; a += 2)
         cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, AW'(a), AW'(a + 1), "post_clr");

      // Reset mid-sweep: sweep restarts from entry 0.
      cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd1, 5'd2, "clr2");
      idle(10, "sweep2");
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd1, 5'd2, "mid_rst");
      idle(DEPTH + 1, "resweep");
      cyc(1'b1, 1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, '0, '0, 5'd9, 5'd0, "final_wr");
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd1, "final_rd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
